pwm_decoder: RTL

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/pwm_decoder_if.sv | 23 ++
 rtl/pwm_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder_if.sv
// Signal bundle between a PWM source and pwm_decoder: waveform/direction in, measurement results out.
interface pwm_decoder_if #(
  parameter int CNT_W = 21
);
  logic             pwm_in;
  logic [1:0]       dir_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [3:0]       code;
  logic             valid;
  logic             stuck;
  logic             dir_err;

  modport master (
    output pwm_in, dir_in,
    input  period, high_time, code, valid, stuck, dir_err
  );

  modport slave (
    input  pwm_in, dir_in,
    output period, high_time, code, valid, stuck, dir_err
  );
endinterface

// File: rtl/pwm_decoder.sv
// PWM period/high-time decoder with duty quantization and stuck-input detection.
// Optional 4-sample glitch filter enabled by defining PWM_DECODER_GLITCH_FILTER_EN.
module pwm_decoder #(
  parameter int CNT_W   = 21,
  parameter int STEP    = 500000,
  parameter int TIMEOUT = 2097151
) (
  input  logic        clk,
  input  logic        res,
  pwm_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } state_t;

  localparam int               QW      = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZRO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [QW-1:0]    THR_1   = QW'(STEP);
  localparam logic [QW-1:0]    THR_3   = QW'(3 * STEP);
  localparam logic [QW-1:0]    THR_5   = QW'(5 * STEP);
  localparam logic [QW-1:0]    THR_7   = QW'(7 * STEP);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Compare 2*h against odd multiples of STEP so half-step thresholds stay exact.
  function automatic logic [2:0] quantize(input logic [CNT_W-1:0] h);
    logic [QW-1:0] h2;
    h2 = {1'b0, h, 1'b0};
    if (h2 < THR_1)      quantize = 3'b000;
    else if (h2 < THR_3) quantize = 3'b001;
    else if (h2 < THR_5) quantize = 3'b010;
    else if (h2 < THR_7) quantize = 3'b100;
    else                 quantize = 3'b111;
  endfunction

  logic             pwm_s1_q, pwm_s2_q, level_q;
  logic [1:0]       dir_s1_q, dir_s2_q;
  logic             level_s, rise_s, fall_s, timeout_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d, high_cnt_q, high_cnt_d, to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_time_q, high_time_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d, stuck_q, stuck_d, dir_err_q, dir_err_d;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pwm_s1_q <= 1'b0;
      pwm_s2_q <= 1'b0;
      dir_s1_q <= 2'b00;
      dir_s2_q <= 2'b00;
      level_q  <= 1'b0;
    end else begin
      pwm_s1_q <= bus.pwm_in;
      pwm_s2_q <= pwm_s1_q;
      dir_s1_q <= bus.dir_in;
      dir_s2_q <= dir_s1_q;
      level_q  <= level_s;
    end
  end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  logic [2:0] hist_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hist_q <= 3'b000;
    end else begin
      hist_q <= {hist_q[1:0], pwm_s2_q};
    end
  end

  // The current sample plus the three before it must agree before the level moves.
  always_comb begin
    level_s = level_q;
    if (hist_q == {3{pwm_s2_q}}) begin
      level_s = pwm_s2_q;
    end else begin
      level_s = level_q;
    end
  end
`else
  always_comb begin
    level_s = pwm_s2_q;
  end
`endif

  assign rise_s    = level_s & ~level_q;
  assign fall_s    = ~level_s & level_q;
  assign timeout_s = (state_q != STUCK) && !rise_s && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q      <= IDLE;
      period_cnt_q <= CNT_ZRO;
      high_cnt_q   <= CNT_ZRO;
      to_cnt_q     <= CNT_ZRO;
      period_q     <= CNT_ZRO;
      high_time_q  <= CNT_ZRO;
      code_q       <= 4'b0000;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      dir_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      to_cnt_q     <= to_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      dir_err_q    <= dir_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    to_cnt_d     = rise_s ? CNT_ZRO : sat_inc(to_cnt_q);
    period_d     = period_q;
    high_time_d  = high_time_q;
    code_d       = code_q;
    valid_d      = 1'b0;
    stuck_d      = stuck_q;
    dir_err_d    = (dir_s2_q[0] == dir_s2_q[1]);

    if (timeout_s) begin
      state_d     = STUCK;
      valid_d     = 1'b1;
      stuck_d     = 1'b1;
      period_d    = CNT_ZRO;
      high_time_d = level_s ? CNT_MAX : CNT_ZRO;
      code_d      = {dir_s2_q[0], {3{level_s}}};
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_s) begin
            state_d      = HIGH;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end
        HIGH: begin
          // The falling-edge cycle is already low, so it counts toward the period only.
          if (fall_s) begin
            state_d      = LOW;
            period_cnt_d = sat_inc(period_cnt_q);
          end else begin
            period_cnt_d = sat_inc(period_cnt_q);
            high_cnt_d   = sat_inc(high_cnt_q);
          end
        end
        LOW: begin
          if (rise_s) begin
            state_d      = HIGH;
            valid_d      = 1'b1;
            period_d     = period_cnt_q;
            high_time_d  = high_cnt_q;
            code_d       = {dir_s2_q[0], quantize(high_cnt_q)};
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
          end else begin
            period_cnt_d = sat_inc(period_cnt_q);
          end
        end
        STUCK: begin
          if (rise_s) begin
            state_d      = HIGH;
            stuck_d      = 1'b0;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
          end else begin
            state_d = STUCK;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_time_q;
  assign bus.code      = code_q;
  assign bus.valid     = valid_q;
  assign bus.stuck     = stuck_q;
  assign bus.dir_err   = dir_err_q;

endmodule
